unified_mem_arbiter: RTL and testbench

Sequencer that shares a single synchronous memory port between the instruction-fetch stage and the data-memory stage of the pipelined MIPS core. It accepts one access at a time and gives data-stage accesses priority, with a starvation limit that guarantees fetch progress. It drives the memory enable, write and address lines, then routes the read response back to the owner after a fixed memory latency. It sits between the IF/MEM pipeline stages and the shared memory macro; requesters stall while their request is not granted.

---
 rtl/unified_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data memory.
// One access is outstanding at a time. The data stage has priority, but a
// starvation limit guarantees that a pending fetch is eventually served.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             grant_if_c, grant_dm_c;
  logic             complete_c;

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      wr_q         <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Same-cycle arbitration, memory issue and latency countdown
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    grant_if_c   = 1'b0;
    grant_dm_c   = 1'b0;
    complete_c   = 1'b0;
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        // Fetch wins only when alone or when the data stage has hit its limit
        if (if_req && (!dm_req || (starve_cnt_q == STARVE_LIM))) begin
          grant_if_c = 1'b1;
        end else if (dm_req) begin
          grant_dm_c = 1'b1;
        end

        if (grant_if_c) begin
          if_gnt       = 1'b1;
          mem_en       = 1'b1;
          mem_addr     = if_addr;
          owner_d      = OWN_IF;
          wr_d         = 1'b0;
          lat_cnt_d    = LAT_LOAD;
          starve_cnt_d = '0;
          state_d      = WAIT;
        end else if (grant_dm_c) begin
          dm_gnt    = 1'b1;
          mem_en    = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          owner_d   = OWN_DM;
          wr_d      = dm_we;
          lat_cnt_d = LAT_LOAD;
          state_d   = WAIT;
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end

      WAIT: begin
        if (lat_cnt_q == '0) begin
          complete_c = 1'b1;
          state_d    = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Route the memory response to its owner; writes return zero data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= complete_c && (owner_q == OWN_IF);
      dm_rvalid <= complete_c && (owner_q == OWN_DM);
      if (complete_c && (owner_q == OWN_IF)) begin
        if_rdata <= mem_rdata;
      end
      if (complete_c && (owner_q == OWN_DM)) begin
        dm_rdata <= wr_q ? '0 : mem_rdata;
      end
    end
  end

  // An access is outstanding
  assign busy = (state_q == WAIT);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a cycle table for the MEM_LAT=2
// instance, plus sequences for starvation, reset mid-access and MEM_LAT=1.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;

  // MEM_LAT = 2 instance
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT = 1 instance
  logic        b_if_req, b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0FFEE00 + 32'(i));
  endfunction

  // Memory model: 16 words, read data valid only in the cycle before it is due
  logic [31:0] mem [16];
  logic [1:0]  v0;
  logic [31:0] d0a, d0b;
  logic        v1;
  logic [31:0] d1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      v0  <= '0;
      d0a <= '0;
      d0b <= '0;
      v1  <= 1'b0;
      d1  <= '0;
    end else begin
      v0[0] <= mem_en && !mem_we;
      d0a   <= mem[mem_addr[5:2]];
      v0[1] <= v0[0];
      d0b   <= d0a;
      if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      v1 <= b_mem_en && !b_mem_we;
      d1 <= mem[b_mem_addr[5:2]];
    end
  end

  assign mem_rdata   = v0[1] ? d0b : 32'hBADBAD00;
  assign b_mem_rdata = v1    ? d1  : 32'hBADBAD11;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_busy;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_dm_rvalid;
    logic [31:0] e_dm_rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t tv [NV];

  bit   ord [10];
  logic own_q [$];
  int   ng;
  int   nf;
  logic exp_g;
  logic own;

  initial begin
    // fetch 0x10, DM read during WAIT, DM write, fetch back the written word
    //          ifr  ifa           dmr   we    dma           dmwd
    //          ig    dg    en    we    maddr         mwdata        busy  irv   irdata        drv   drdata
    tv[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[1]  = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        32'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0C,       32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0C,       32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0C,       32'h0,
               1'b0, 1'b1, 1'b1, 1'b0, 32'h0C,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[6]  = tv[5];
    tv[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h20,       32'h5A5A,
               1'b0, 1'b1, 1'b1, 1'b1, 32'h20,       32'h5A5A,     1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hC0FFEE03};
    tv[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'hC0FFEE03};
    tv[9]  = tv[8];
    tv[10] = '{1'b1, 32'h20,       1'b0, 1'b0, 32'h0,        32'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    tv[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[12] = tv[11];
    tv[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00005A5A, 1'b0, 32'h0};

    ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    clk = 1'b0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_dm_rdata", dm_rdata, 32'h0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_dm_gnt", dm_gnt, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Cycle table
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      if_req   = tv[i].if_req;
      if_addr  = tv[i].if_addr;
      dm_req   = tv[i].dm_req;
      dm_we    = tv[i].dm_we;
      dm_addr  = tv[i].dm_addr;
      dm_wdata = tv[i].dm_wdata;
      @(negedge clk);
      chk1($sformatf("row%0d_if_gnt", i), if_gnt, tv[i].e_if_gnt);
      chk1($sformatf("row%0d_dm_gnt", i), dm_gnt, tv[i].e_dm_gnt);
      chk1($sformatf("row%0d_mem_en", i), mem_en, tv[i].e_mem_en);
      chk1($sformatf("row%0d_mem_we", i), mem_we, tv[i].e_mem_we);
      chk32($sformatf("row%0d_mem_addr", i), mem_addr, tv[i].e_mem_addr);
      chk32($sformatf("row%0d_mem_wdata", i), mem_wdata, tv[i].e_mem_wdata);
      chk1($sformatf("row%0d_busy", i), busy, tv[i].e_busy);
      chk1($sformatf("row%0d_if_rvalid", i), if_rvalid, tv[i].e_if_rvalid);
      chk32($sformatf("row%0d_if_rdata", i), if_rdata, tv[i].e_if_rdata);
      chk1($sformatf("row%0d_dm_rvalid", i), dm_rvalid, tv[i].e_dm_rvalid);
      chk32($sformatf("row%0d_dm_rdata", i), dm_rdata, tv[i].e_dm_rdata);
    end

    // Starvation: both requests held; expect D D D D I D D D D I
    ng = 0;
    for (int c = 0; c < 80 && (ng < 10 || own_q.size() > 0); c++) begin
      @(posedge clk);
      #1;
      if_req  = (ng < 10);
      if_addr = 32'h04;
      dm_req  = (ng < 10);
      dm_we   = 1'b0;
      dm_addr = 32'h08;
      @(negedge clk);
      if (if_gnt && dm_gnt) chk1("starve_dual_gnt", 1'b1, 1'b0);
      if (if_rvalid || dm_rvalid) begin
        if (own_q.size() == 0) begin
          chk1("starve_spurious_rvalid", 1'b1, 1'b0);
        end else begin
          own = own_q.pop_front();
          chk1("starve_rv_owner", dm_rvalid, own);
          chk1("starve_rv_single", if_rvalid, !own);
          if (own) chk32("starve_dm_rdata", dm_rdata, 32'hC0FFEE02);
          else     chk32("starve_if_rdata", if_rdata, 32'hC0FFEE01);
        end
      end
      if ((if_gnt || dm_gnt) && ng < 10) begin
        chk1($sformatf("starve_order%0d", ng), dm_gnt, ord[ng]);
        own_q.push_back(dm_gnt);
        ng++;
      end
    end
    chk32("starve_grant_count", 32'(ng), 32'd10);
    chk32("starve_pending", 32'(own_q.size()), 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;

    // Reset one cycle after a DM read grant discards the response
    @(posedge clk);
    #1;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0C;
    @(negedge clk);
    chk1("rstmid_dm_gnt", dm_gnt, 1'b1);
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    chk1("rstmid_busy", busy, 1'b0);
    chk32("rstmid_dm_rdata", dm_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("rstmid_no_dm_rvalid", dm_rvalid, 1'b0);
      chk32("rstmid_dm_rdata_hold", dm_rdata, 32'h0);
      chk1("rstmid_idle", busy, 1'b0);
      @(posedge clk);
    end
    #1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    chk1("rstmid_fresh_gnt", if_gnt, 1'b1);
    @(posedge clk);
    #1 if_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rstmid_fresh_rvalid", if_rvalid, 1'b1);
    chk32("rstmid_fresh_rdata", if_rdata, 32'hDEADBEEF);

    // MEM_LAT=1: back-to-back fetches, a grant every second cycle
    nf = 0;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk);
      #1;
      b_if_req  = (nf < 6);
      b_if_addr = 32'(nf * 4);
      @(negedge clk);
      exp_g = (c % 2 == 0) && (c <= 10);
      chk1($sformatf("lat1_gnt_c%0d", c), b_if_gnt, exp_g);
      chk1($sformatf("lat1_mem_en_c%0d", c), b_mem_en, exp_g);
      chk1($sformatf("lat1_rvalid_c%0d", c), b_if_rvalid, (c % 2 == 0) && (c >= 2));
      if ((c % 2 == 0) && (c >= 2))
        chk32($sformatf("lat1_rdata_c%0d", c), b_if_rdata, init_word(c / 2 - 1));
      if (b_if_gnt) nf++;
    end
    b_if_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
